// File: rtl/alu_share_sched_32b.sv
// Two-requester scheduler sharing one combinational function unit.
// It holds one operation in flight and uses a round-robin grant with per-requester response registers.
module alu_share_sched_32b #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 2,
  parameter int DIV_LAT = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic             req1_valid,
  output logic             req0_ready,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [3:0]       req0_op,
  input  logic [3:0]       req1_op,
  output logic             rsp0_valid,
  output logic             rsp1_valid,
  input  logic             rsp0_ready,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp0_data,
  output logic [WIDTH-1:0] rsp1_data,
  output logic             rsp0_err,
  output logic             rsp1_err,
  output logic [WIDTH-1:0] fu_a,
  output logic [WIDTH-1:0] fu_b,
  output logic [3:0]       fu_select,
  input  logic [WIDTH-1:0] fu_out,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  state_t             state_r, state_nx_s;
  logic [3:0]         cnt_r;
  logic               last_r, owner_r;
  logic [WIDTH-1:0]   a_r, b_r, data0_r, data1_r;
  logic [3:0]         op_r;
  logic               valid0_r, valid1_r, err0_r, err1_r;
  logic               grant0_s, grant1_s, accept_s, hs_s;
  logic [WIDTH-1:0]   acc_a_s, acc_b_s;
  logic [3:0]         acc_op_s;
  logic               res_load_s, res_owner_s, res_err_s;
  logic [WIDTH-1:0]   res_data_s;

  function automatic logic [3:0] lat_m1(input logic [3:0] op);
    case (op)
      4'd1:    return 4'(MUL_LAT - 1);
      4'd3:    return 4'(DIV_LAT - 1);
      default: return 4'd0;
    endcase
  endfunction

  assign hs_s = (valid0_r && rsp0_ready) || (valid1_r && rsp1_ready);

  // Grant, next state and result-capture selection.
  always_comb begin
    state_nx_s  = state_r;
    grant0_s    = 1'b0;
    grant1_s    = 1'b0;
    acc_a_s     = req0_a;
    acc_b_s     = req0_b;
    acc_op_s    = req0_op;
    res_load_s  = 1'b0;
    res_owner_s = owner_r;
    res_err_s   = 1'b0;
    res_data_s  = {WIDTH{1'b0}};
    case (state_r)
      IDLE: begin
        if (req0_valid && (!req1_valid || last_r)) begin
          grant0_s = 1'b1;
        end else if (req1_valid) begin
          grant1_s = 1'b1;
          acc_a_s  = req1_a;
          acc_b_s  = req1_b;
          acc_op_s = req1_op;
        end else begin
          grant0_s = 1'b0;
        end
        if (grant0_s || grant1_s) begin
          // Undefined opcodes complete immediately with an error result.
          if (acc_op_s >= 4'd10) begin
            state_nx_s  = RESP;
            res_load_s  = 1'b1;
            res_owner_s = grant1_s;
            res_err_s   = 1'b1;
          end else begin
            state_nx_s = EXEC;
          end
        end else begin
          state_nx_s = IDLE;
        end
      end
      EXEC: begin
        if (cnt_r == 4'd0) begin
          state_nx_s = RESP;
          res_load_s = 1'b1;
          if (op_r == 4'd3 && b_r == {WIDTH{1'b0}}) begin
            res_data_s = {WIDTH{1'b1}};
            res_err_s  = 1'b1;
          end else begin
            res_data_s = fu_out;
          end
        end else begin
          state_nx_s = EXEC;
        end
      end
      RESP: begin
        if (hs_s) begin
          state_nx_s = IDLE;
        end else begin
          state_nx_s = RESP;
        end
      end
      default: state_nx_s = IDLE;
    endcase
  end

  assign accept_s = grant0_s || grant1_s;

  // State, operand latches, latency counter and response registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r  <= IDLE;
      cnt_r    <= 4'd0;
      last_r   <= 1'b1;
      owner_r  <= 1'b0;
      a_r      <= {WIDTH{1'b0}};
      b_r      <= {WIDTH{1'b0}};
      op_r     <= 4'd0;
      data0_r  <= {WIDTH{1'b0}};
      data1_r  <= {WIDTH{1'b0}};
      valid0_r <= 1'b0;
      valid1_r <= 1'b0;
      err0_r   <= 1'b0;
      err1_r   <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      if (accept_s) begin
        a_r     <= acc_a_s;
        b_r     <= acc_b_s;
        op_r    <= acc_op_s;
        owner_r <= grant1_s;
        cnt_r   <= lat_m1(acc_op_s);
      end else if (state_r == EXEC && cnt_r != 4'd0) begin
        cnt_r <= cnt_r - 4'd1;
      end
      if (res_load_s) begin
        if (res_owner_s) begin
          data1_r  <= res_data_s;
          err1_r   <= res_err_s;
          valid1_r <= 1'b1;
        end else begin
          data0_r  <= res_data_s;
          err0_r   <= res_err_s;
          valid0_r <= 1'b1;
        end
      end
      if (state_r == RESP && hs_s) begin
        valid0_r <= 1'b0;
        valid1_r <= 1'b0;
        err0_r   <= 1'b0;
        err1_r   <= 1'b0;
        last_r   <= owner_r;
      end
    end
  end

  assign req0_ready = grant0_s;
  assign req1_ready = grant1_s;
  assign rsp0_valid = valid0_r;
  assign rsp1_valid = valid1_r;
  assign rsp0_data  = data0_r;
  assign rsp1_data  = data1_r;
  assign rsp0_err   = err0_r;
  assign rsp1_err   = err1_r;
  assign fu_a       = a_r;
  assign fu_b       = b_r;
  assign fu_select  = op_r;
  assign busy       = (state_r != IDLE);

endmodule

// File: tb/tb_alu_share_sched_32b.sv
// Directed bench for alu_share_sched_32b; the bench models the shared function unit itself.
module tb_alu_share_sched_32b;
  logic        clock = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_op, req1_op;
  logic        rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
  logic [31:0] rsp0_data, rsp1_data;
  logic        rsp0_err, rsp1_err;
  logic [31:0] fu_a, fu_b, fu_out;
  logic [3:0]  fu_select;
  logic        busy;
  int          total = 0;
  int          bad = 0;

  alu_share_sched_32b dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .req0_op(req0_op), .req1_op(req1_op),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
    .rsp0_ready(rsp0_ready), .rsp1_ready(rsp1_ready),
    .rsp0_data(rsp0_data), .rsp1_data(rsp1_data),
    .rsp0_err(rsp0_err), .rsp1_err(rsp1_err),
    .fu_a(fu_a), .fu_b(fu_b), .fu_select(fu_select), .fu_out(fu_out),
    .busy(busy)
  );

  always #5 clock = ~clock;

  always_comb begin
    case (fu_select)
      4'd0:    fu_out = fu_a + fu_b;
      4'd1:    fu_out = fu_a * fu_b;
      4'd2:    fu_out = fu_a - fu_b;
      4'd3:    fu_out = (fu_b == 32'd0) ? 32'h1234_5678 : fu_a / fu_b;
      4'd4:    fu_out = fu_a & fu_b;
      4'd5:    fu_out = fu_a | fu_b;
      4'd6:    fu_out = fu_a ^ fu_b;
      4'd7:    fu_out = fu_a << fu_b[4:0];
      4'd8:    fu_out = 32'($signed(fu_a) >>> fu_b[4:0]);
      4'd9:    fu_out = fu_a >> fu_b[4:0];
      default: fu_out = 32'hDEAD_BEEF;
    endcase
  end

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = 32'd0; req0_b = 32'd0; req1_a = 32'd0; req1_b = 32'd0;
    req0_op = 4'd0; req1_op = 4'd0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    step; step;
    reset = 1'b0;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
    chk("rst_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
    chk("rst_rsp0_err", {31'd0, rsp0_err}, 32'd0);
    chk("rst_fu_a", fu_a, 32'd0);
    chk("rst_fu_sel", {28'd0, fu_select}, 32'd0);
    chk("rst_rsp0_data", rsp0_data, 32'd0);
    chk("rst_req0_ready", {31'd0, req0_ready}, 32'd0);

    // Tie right after reset: grants alternate 0,1,0,1
    req0_valid = 1'b1; req0_a = 32'd1;  req0_b = 32'd2;  req0_op = 4'd0;
    req1_valid = 1'b1; req1_a = 32'd10; req1_b = 32'd20; req1_op = 4'd0;
    #1;
    chk("rr0_req0_ready", {31'd0, req0_ready}, 32'd1);
    chk("rr0_req1_ready", {31'd0, req1_ready}, 32'd0);
    step; step;
    chk("rr0_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
    chk("rr0_rsp0_data", rsp0_data, 32'd3);
    chk("rr0_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
    step;
    chk("rr1_req1_ready", {31'd0, req1_ready}, 32'd1);
    chk("rr1_req0_ready", {31'd0, req0_ready}, 32'd0);
    step; step;
    chk("rr1_rsp1_data", rsp1_data, 32'd30);
    step;
    chk("rr2_req0_ready", {31'd0, req0_ready}, 32'd1);
    step; step; step;
    chk("rr3_req1_ready", {31'd0, req1_ready}, 32'd1);
    chk("rr3_req0_ready", {31'd0, req0_ready}, 32'd0);
    step; step; step;
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Single add 5+7, with operand changes after accept
    req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd7; req0_op = 4'd0;
    #1;
    chk("add_req0_ready", {31'd0, req0_ready}, 32'd1);
    step;
    req0_valid = 1'b0; req0_a = 32'd99; req0_op = 4'd1;
    #1;
    chk("add_busy_exec", {31'd0, busy}, 32'd1);
    chk("add_fu_a", fu_a, 32'd5);
    chk("add_fu_b", fu_b, 32'd7);
    chk("add_rsp0_early", {31'd0, rsp0_valid}, 32'd0);
    step;
    chk("add_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
    chk("add_rsp0_data", rsp0_data, 32'd12);
    chk("add_rsp0_err", {31'd0, rsp0_err}, 32'd0);
    chk("add_busy_resp", {31'd0, busy}, 32'd1);
    step;
    chk("add_rsp0_done", {31'd0, rsp0_valid}, 32'd0);
    chk("add_busy_idle", {31'd0, busy}, 32'd0);

    // Divide 100/7 on requester 1, four cycle latency
    req1_valid = 1'b1; req1_a = 32'd100; req1_b = 32'd7; req1_op = 4'd3;
    #1;
    chk("div_req1_ready", {31'd0, req1_ready}, 32'd1);
    step;
    req1_valid = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      step;
      chk($sformatf("div_wait%0d", i), {31'd0, rsp1_valid}, 32'd0);
    end
    step;
    chk("div_rsp1_valid", {31'd0, rsp1_valid}, 32'd1);
    chk("div_rsp1_data", rsp1_data, 32'd14);
    chk("div_rsp1_err", {31'd0, rsp1_err}, 32'd0);
    step;

    // Divide by zero
    req1_valid = 1'b1; req1_a = 32'd5; req1_b = 32'd0; req1_op = 4'd3;
    step;
    req1_valid = 1'b0;
    step; step; step; step;
    chk("dz_rsp1_valid", {31'd0, rsp1_valid}, 32'd1);
    chk("dz_rsp1_data", rsp1_data, 32'hFFFF_FFFF);
    chk("dz_rsp1_err", {31'd0, rsp1_err}, 32'd1);
    step;
    chk("dz_err_clear", {31'd0, rsp1_err}, 32'd0);

    // Illegal opcode 12
    req0_valid = 1'b1; req0_a = 32'd3; req0_b = 32'd4; req0_op = 4'd12;
    step;
    req0_valid = 1'b0;
    chk("ill_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
    chk("ill_rsp0_data", rsp0_data, 32'd0);
    chk("ill_rsp0_err", {31'd0, rsp0_err}, 32'd1);
    step;

    // Backpressure: rsp0_ready low for 5 cycles while req1 waits
    rsp0_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 32'd50; req0_b = 32'd8; req0_op = 4'd2;
    step;
    req0_valid = 1'b0;
    step;
    req1_valid = 1'b1; req1_a = 32'hF0; req1_b = 32'h3C; req1_op = 4'd4;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("bp_data%0d", i), rsp0_data, 32'd42);
      chk($sformatf("bp_req1_ready%0d", i), {31'd0, req1_ready}, 32'd0);
      step;
    end
    chk("bp_rsp0_hold", {31'd0, rsp0_valid}, 32'd1);
    rsp0_ready = 1'b1;
    step;
    chk("bp_rsp0_done", {31'd0, rsp0_valid}, 32'd0);
    chk("bp_req1_ready", {31'd0, req1_ready}, 32'd1);
    step;
    req1_valid = 1'b0;
    step;
    chk("bp_rsp1_data", rsp1_data, 32'h30);
    step;

    // Reset during a multiply discards it
    req0_valid = 1'b1; req0_a = 32'd6; req0_b = 32'd7; req0_op = 4'd1;
    step;
    req0_valid = 1'b0;
    reset = 1'b1;
    step;
    reset = 1'b0;
    chk("mrst_busy", {31'd0, busy}, 32'd0);
    chk("mrst_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
    chk("mrst_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
    step;
    chk("mrst_no_rsp", {31'd0, rsp0_valid}, 32'd0);
    req0_valid = 1'b1; req1_valid = 1'b1; req1_op = 4'd0;
    #1;
    chk("mrst_tie_req0", {31'd0, req0_ready}, 32'd1);
    step;
    req0_valid = 1'b0; req1_valid = 1'b0;
    step;
    chk("mul_wait", {31'd0, rsp0_valid}, 32'd0);
    step;
    chk("mul_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
    chk("mul_rsp0_data", rsp0_data, 32'd42);
    step;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_share_sched_32b.md
ALU_SHARE_SCHED_32B -- requirements
Module: alu_share_sched_32b

Interface
REQ-001: Parameter WIDTH, default 32, operand and result width in bits.
REQ-002: Parameter MUL_LAT, default 2, EXEC cycles for op 1 (multiply), range 1..15.
REQ-003: Parameter DIV_LAT, default 4, EXEC cycles for op 3 (divide), range 1..15.
REQ-004: clock  in  1  single clock; all state updates on its rising edge.
REQ-005: reset  in  1  synchronous, active-high reset.
REQ-006: req0_valid, req1_valid  in  1  requester n presents an operation.
REQ-007: req0_ready, req1_ready  out  1  scheduler accepts requester n this cycle.
REQ-008: req0_a, req0_b, req1_a, req1_b  in  WIDTH  operands of requester n.
REQ-009: req0_op, req1_op  in  4  opcode: 0 add, 1 mul, 2 sub, 3 div, 4 and, 5 or, 6 xor, 7 shl, 8 ashr, 9 lshr.
REQ-010: rsp0_valid, rsp1_valid  out  1  result for requester n is available.
REQ-011: rsp0_ready, rsp1_ready  in  1  requester n consumes its result.
REQ-012: rsp0_data, rsp1_data  out  WIDTH  result for requester n.
REQ-013: rsp0_err, rsp1_err  out  1  result for requester n is an error result.
REQ-014: fu_a, fu_b  out  WIDTH  operands driven to the shared combinational function unit.
REQ-015: fu_select  out  4  opcode driven to the function unit.
REQ-016: fu_out  in  WIDTH  combinational function unit result.
REQ-017: busy  out  1  high whenever the state is not IDLE.

Function
REQ-018: FSM states are IDLE, EXEC and RESP; the block holds at most one operation in flight.
REQ-019: In IDLE, the scheduler asserts exactly one reqN_ready, and only when that reqN_valid is high.
REQ-020: Grant rule in IDLE: a single valid requester wins; with both valid, the requester not served last wins (round-robin).
REQ-021: The last-served pointer updates only on response handshake and resets to 1, so requester 0 wins the first tie.
REQ-022: Acceptance occurs on reqN_valid && reqN_ready; the scheduler latches a, b, op and the owner ID into internal registers.
REQ-023: fu_a, fu_b and fu_select are driven from the latched registers and stay stable through EXEC and RESP.
REQ-024: On acceptance of op 0..9, the FSM enters EXEC with the cycle counter loaded to LAT-1.
REQ-025: LAT is MUL_LAT for op 1, DIV_LAT for op 3, and 1 for all other ops.
REQ-026: In EXEC, the counter decrements each cycle; when the counter equals 0, the scheduler captures fu_out into the owner's rsp data register and moves to RESP.
REQ-027: Op 3 with b == 0 does not sample fu_out; the scheduler captures all-ones data with err=1.
REQ-028: Opcodes 10..15 skip EXEC; the FSM moves directly to RESP with data 0 and err=1.
REQ-029: In RESP, rspN_valid is high for the owner only; the other requester's rsp_valid is 0.
REQ-030: rspN_data and rspN_err hold stable while rspN_valid is high.
REQ-031: On rspN_valid && rspN_ready, the FSM returns to IDLE and the owner becomes last-served; the response clears to valid 0 and the err register clears.
REQ-032: Both reqN_ready are 0 in EXEC and RESP; a new request is never accepted in the same cycle as a response handshake.
REQ-033: Latency from accept edge to rsp_valid high is LAT cycles; back-to-back throughput is one op per LAT+2 cycles when rsp_ready is held high.
REQ-034: Changes on req inputs after acceptance have no effect on the in-flight operation.
REQ-035: Arithmetic is WIDTH-bit; the scheduler never widens or truncates fu_out.

Reset
REQ-036: With reset high at a clock edge, the FSM enters IDLE, the counter becomes 0 and the last-served pointer becomes 1.
REQ-037: Reset values: all req_ready, rsp_valid, rsp_err, busy, fu_a, fu_b and fu_select are 0; rsp data registers are 0.
REQ-038: Reset asserted during EXEC or RESP discards the in-flight operation, and no response is issued.

Verification
REQ-039: Single request, req0 op 0, a=5, b=7 -> req0_ready at cycle 0; rsp0_valid from cycle 1 with data 12 and err 0; busy high cycles 1..1 plus RESP.
REQ-040: Both valid in the first IDLE cycle after reset -> req0 granted first; after its response, req1 granted; with both held valid, grants alternate 0,1,0,1.
REQ-041: req1 op 3, a=100, b=7, DIV_LAT=4 -> rsp1_valid exactly 4 cycles after accept with data 14; op 3 with b=0 -> data 0xFFFFFFFF and err 1.
REQ-042: req0 op 12 -> rsp0_valid the cycle after accept with data 0 and err 1; fu_out is ignored.
REQ-043: rsp0_ready held low for 5 cycles in RESP -> rsp0_data stable, req1_ready stays 0 despite req1_valid=1; req1 is accepted the cycle after the handshake.
REQ-044: Reset pulsed during EXEC of a multiply -> next cycle IDLE, busy 0, all rsp_valid 0; the following request is served normally, with req0 winning a tie.
